// File: rtl/ballot_session_ctrl.sv
// ballot_session_ctrl
//   Front-end session sequencer for the voting path. Conditions the enter key
//   and the four candidate buttons (2-flop sync + debounce + rising-edge pulse),
//   latches the voter UID on enter, runs a timed ARMED window, offers exactly
//   one one-hot vote per session over valid/ready, then holds a lockout.
//
//   Ports
//     clock, reset        : single clock, synchronous active-high reset
//     mode                : 1 = voting mode (static switch, not conditioned)
//     enter, candidate1..4: raw panel buttons
//     UID[5:0]            : voter ID switches, captured on accepted enter
//     vote_ready          : downstream accepts the vote this cycle
//     uid_out[5:0]        : latched UID (0 in IDLE / HOLD)
//     voter_enter         : high in ARMED and PENDING
//     vote_sel[3:0]       : one-hot candidate, bit0 = candidate1
//     vote_valid          : vote offered downstream (PENDING)
//     vote_done_led       : high during HOLD
//     timeout_pulse       : one cycle, first IDLE cycle after ARMED timeout
//     reject_pulse        : one cycle after a rejected candidate press
//     state[1:0]          : IDLE=0, ARMED=1, PENDING=2, HOLD=3

// Per-button conditioning lane: sync, debounce, press pulse.
module ballot_btn_cond #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic press
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             sync1_q, sync2_q;
  logic             clean_q, clean_d;
  logic             clean_dly_q;
  logic             press_q, press_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Count consecutive mismatching samples; the clean level flips on the
  // DEBOUNCE_CYCLES-th one. Any matching sample restarts the count.
  always_comb begin
    clean_d = clean_q;
    cnt_d   = '0;
    if (sync2_q != clean_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        clean_d = ~clean_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    // Rising edge detected one cycle after the clean flip, so the pulse
    // lands DEBOUNCE_CYCLES+2 edges after the raw input is first sampled.
    press_d = clean_q & ~clean_dly_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      clean_q     <= 1'b0;
      clean_dly_q <= 1'b0;
      cnt_q       <= '0;
      press_q     <= 1'b0;
    end else begin
      sync1_q     <= raw;
      sync2_q     <= sync1_q;
      clean_q     <= clean_d;
      clean_dly_q <= clean_q;
      cnt_q       <= cnt_d;
      press_q     <= press_d;
    end
  end

  assign press = press_q;
endmodule

module ballot_session_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int ARM_TIMEOUT     = 1000,
  parameter int HOLD_CYCLES     = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       mode,
  input  logic       enter,
  input  logic       candidate1,
  input  logic       candidate2,
  input  logic       candidate3,
  input  logic       candidate4,
  input  logic [5:0] UID,
  input  logic       vote_ready,
  output logic [5:0] uid_out,
  output logic       voter_enter,
  output logic [3:0] vote_sel,
  output logic       vote_valid,
  output logic       vote_done_led,
  output logic       timeout_pulse,
  output logic       reject_pulse,
  output logic [1:0] state
);
  localparam int NUM_BTN = 5;
  localparam int TMR_W   = $clog2(ARM_TIMEOUT + 1);
  localparam int HLD_W   = $clog2(HOLD_CYCLES + 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ARMED   = 2'd1;
  localparam logic [1:0] PENDING = 2'd2;
  localparam logic [1:0] HOLD    = 2'd3;

  // bit0 = enter, bits[4:1] = candidate1..4
  logic [NUM_BTN-1:0] btn_raw, press;
  assign btn_raw = {candidate4, candidate3, candidate2, candidate1, enter};

  ballot_btn_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cond [NUM_BTN-1:0] (
    .clock (clock),
    .reset (reset),
    .raw   (btn_raw),
    .press (press)
  );

  logic [3:0] cand_p;
  logic       enter_p, cand_any, cand_one;
  assign enter_p  = press[0];
  assign cand_p   = press[4:1];
  assign cand_any = |cand_p;
  assign cand_one = cand_any && ((cand_p & (cand_p - 4'd1)) == 4'd0);

  logic [1:0]       state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [HLD_W-1:0] hold_q, hold_d;
  logic [5:0]       uid_q, uid_d;
  logic [3:0]       sel_q, sel_d;
  logic             to_q, to_d, rej_q, rej_d;
  logic             enter_q, valid_q, led_q;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    hold_d  = hold_q;
    uid_d   = uid_q;
    sel_d   = sel_q;
    to_d    = 1'b0;
    rej_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (cand_any) rej_d = 1'b1;
        if (enter_p && mode) begin
          uid_d   = UID;
          timer_d = TMR_W'(ARM_TIMEOUT);
          state_d = ARMED;
        end
      end
      ARMED: begin
        if (!mode) begin
          state_d = IDLE;
          uid_d   = '0;
          timer_d = '0;
        end else if (enter_p) begin
          // Re-enter restarts the window and wins over a same-cycle candidate.
          uid_d   = UID;
          timer_d = TMR_W'(ARM_TIMEOUT);
        end else if (cand_one) begin
          sel_d   = cand_p;
          timer_d = '0;
          state_d = PENDING;
        end else begin
          // Multi-press rejects but does not stop the window from expiring.
          if (cand_any) rej_d = 1'b1;
          if (timer_q == TMR_W'(1)) begin
            to_d    = 1'b1;
            state_d = IDLE;
            uid_d   = '0;
            timer_d = '0;
          end else begin
            timer_d = timer_q - TMR_W'(1);
          end
        end
      end
      PENDING: begin
        // Nothing but the handshake can leave PENDING.
        if (valid_q && vote_ready) begin
          hold_d  = HLD_W'(HOLD_CYCLES);
          uid_d   = '0;
          sel_d   = '0;
          state_d = HOLD;
        end
      end
      default: begin
        if (hold_q == HLD_W'(1)) begin
          hold_d  = '0;
          state_d = IDLE;
        end else begin
          hold_d = hold_q - HLD_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      timer_q <= '0;
      hold_q  <= '0;
      uid_q   <= '0;
      sel_q   <= '0;
      to_q    <= 1'b0;
      rej_q   <= 1'b0;
      enter_q <= 1'b0;
      valid_q <= 1'b0;
      led_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      hold_q  <= hold_d;
      uid_q   <= uid_d;
      sel_q   <= sel_d;
      to_q    <= to_d;
      rej_q   <= rej_d;
      enter_q <= (state_d == ARMED) || (state_d == PENDING);
      valid_q <= (state_d == PENDING);
      led_q   <= (state_d == HOLD);
    end
  end

  assign uid_out       = uid_q;
  assign voter_enter   = enter_q;
  assign vote_sel      = sel_q;
  assign vote_valid    = valid_q;
  assign vote_done_led = led_q;
  assign timeout_pulse = to_q;
  assign reject_pulse  = rej_q;
  assign state         = state_q;
endmodule

// File: tb/tb_ballot_session_ctrl.sv
module tb_ballot_session_ctrl;
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ARMED   = 2'd1;
  localparam logic [1:0] PENDING = 2'd2;
  localparam logic [1:0] HOLD    = 2'd3;

  logic       clock = 1'b0;
  logic       reset, mode, enter;
  logic       candidate1, candidate2, candidate3, candidate4;
  logic [5:0] UID;
  logic       vote_ready;
  logic [5:0] uid_out;
  logic       voter_enter, vote_valid, vote_done_led, timeout_pulse, reject_pulse;
  logic [3:0] vote_sel;
  logic [1:0] state;
  logic [16:0] outs;

  int passed = 0;
  int total  = 0;

  always #5 clock = ~clock;

  ballot_session_ctrl #(
    .DEBOUNCE_CYCLES(4), .ARM_TIMEOUT(16), .HOLD_CYCLES(8)
  ) dut (
    .clock(clock), .reset(reset), .mode(mode), .enter(enter),
    .candidate1(candidate1), .candidate2(candidate2),
    .candidate3(candidate3), .candidate4(candidate4),
    .UID(UID), .vote_ready(vote_ready),
    .uid_out(uid_out), .voter_enter(voter_enter), .vote_sel(vote_sel),
    .vote_valid(vote_valid), .vote_done_led(vote_done_led),
    .timeout_pulse(timeout_pulse), .reject_pulse(reject_pulse), .state(state)
  );

  assign outs = {uid_out, voter_enter, vote_sel, vote_valid, vote_done_led,
                 timeout_pulse, reject_pulse, state};

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; mode = 1'b0; enter = 1'b0; UID = 6'd0; vote_ready = 1'b0;
    candidate1 = 1'b0; candidate2 = 1'b0; candidate3 = 1'b0; candidate4 = 1'b0;
    tick(2);
    chk("reset_outs", 32'(outs), 32'd0);
    reset = 1'b0;
    tick(1);
    chk("idle_after_reset", 32'(state), 32'(IDLE));

    // Basic vote: enter held 10 cycles, then candidate3 with ready high.
    mode = 1'b1; UID = 6'd5; vote_ready = 1'b1; enter = 1'b1;
    tick(7);
    chk("t1_pre_arm", 32'(state), 32'(IDLE));
    tick(1);
    chk("t1_armed", 32'({state, voter_enter, uid_out}), 32'({ARMED, 1'b1, 6'd5}));
    tick(2);
    enter = 1'b0; candidate3 = 1'b1;
    tick(7);
    chk("t1_still_armed", 32'({state, vote_valid}), 32'({ARMED, 1'b0}));
    tick(1);
    chk("t1_pending", 32'({state, vote_valid, vote_sel, uid_out}),
        32'({PENDING, 1'b1, 4'b0100, 6'd5}));
    candidate3 = 1'b0;
    tick(1);
    chk("t1_hold", 32'({state, vote_valid, vote_done_led, uid_out, vote_sel}),
        32'({HOLD, 1'b0, 1'b1, 6'd0, 4'd0}));
    tick(7);
    chk("t1_hold_last", 32'({state, vote_done_led}), 32'({HOLD, 1'b1}));
    tick(1);
    chk("t1_idle", 32'({state, vote_done_led, uid_out, voter_enter}),
        32'({IDLE, 1'b0, 6'd0, 1'b0}));

    // Backpressure: 20 cycles of ready low, candidate1 toggled, mode dropped.
    vote_ready = 1'b0; UID = 6'd12; enter = 1'b1;
    tick(8);
    chk("t2_armed", 32'({state, uid_out}), 32'({ARMED, 6'd12}));
    enter = 1'b0; candidate2 = 1'b1;
    tick(8);
    chk("t2_pending", 32'({state, vote_valid, vote_sel}), 32'({PENDING, 1'b1, 4'b0010}));
    candidate2 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      candidate1 = (i < 10);
      mode = (i < 5);
      tick(1);
      chk("t2_stall", 32'({reject_pulse, state, vote_valid, vote_sel, uid_out}),
          32'({1'b0, PENDING, 1'b1, 4'b0010, 6'd12}));
    end
    vote_ready = 1'b1;
    tick(1);
    chk("t2_xfer", 32'({state, vote_valid, vote_done_led}), 32'({HOLD, 1'b0, 1'b1}));
    tick(8);
    chk("t2_idle", 32'(state), 32'(IDLE));

    // Timeout: enter only, window of 16 cycles.
    mode = 1'b1; enter = 1'b1;
    tick(8);
    chk("t3_armed", 32'(state), 32'(ARMED));
    enter = 1'b0;
    tick(15);
    chk("t3_pre_timeout", 32'({state, timeout_pulse}), 32'({ARMED, 1'b0}));
    tick(1);
    chk("t3_timeout", 32'({state, timeout_pulse, uid_out, vote_valid, voter_enter}),
        32'({IDLE, 1'b1, 6'd0, 1'b0, 1'b0}));
    tick(1);
    chk("t3_pulse_width", 32'(timeout_pulse), 32'd0);

    // Rejects: candidate2 in IDLE, candidate1+4 together in ARMED.
    candidate2 = 1'b1;
    tick(7);
    chk("t4_pre_reject", 32'(reject_pulse), 32'd0);
    tick(1);
    chk("t4_idle_reject", 32'({state, reject_pulse}), 32'({IDLE, 1'b1}));
    candidate2 = 1'b0;
    tick(1);
    chk("t4_reject_width", 32'(reject_pulse), 32'd0);
    tick(6);
    enter = 1'b1;
    tick(8);
    chk("t4_armed", 32'(state), 32'(ARMED));
    enter = 1'b0; candidate1 = 1'b1; candidate4 = 1'b1;
    tick(8);
    chk("t4_multi_reject", 32'({state, reject_pulse, vote_valid}), 32'({ARMED, 1'b1, 1'b0}));
    candidate1 = 1'b0; candidate4 = 1'b0;
    tick(1);
    chk("t4_still_armed", 32'({state, reject_pulse, vote_valid}), 32'({ARMED, 1'b0, 1'b0}));
    mode = 1'b0;
    tick(1);
    chk("t4_mode_drop", 32'({state, timeout_pulse, uid_out, voter_enter}),
        32'({IDLE, 1'b0, 6'd0, 1'b0}));

    // Debounce: two 3-cycle glitches, enter reload with new UID, real press.
    mode = 1'b1; UID = 6'd3; enter = 1'b1;
    tick(8);
    chk("t5_armed", 32'({state, uid_out}), 32'({ARMED, 6'd3}));
    enter = 1'b0; candidate1 = 1'b1;
    tick(3);
    candidate1 = 1'b0;
    tick(3);
    candidate1 = 1'b1; UID = 6'd9; enter = 1'b1;
    tick(3);
    candidate1 = 1'b0;
    tick(4);
    chk("t5_glitch_no_vote", 32'({state, vote_valid, uid_out}), 32'({ARMED, 1'b0, 6'd3}));
    tick(1);
    chk("t5_reload", 32'({state, uid_out}), 32'({ARMED, 6'd9}));
    enter = 1'b0; candidate1 = 1'b1;
    tick(6);
    candidate1 = 1'b0;
    tick(1);
    chk("t5_pre_vote", 32'(state), 32'(ARMED));
    tick(1);
    chk("t5_vote", 32'({state, vote_valid, vote_sel, uid_out}),
        32'({PENDING, 1'b1, 4'b0001, 6'd9}));
    tick(1);
    chk("t5_hold", 32'(state), 32'(HOLD));
    tick(8);
    chk("t5_idle", 32'(state), 32'(IDLE));

    // Reset in PENDING.
    vote_ready = 1'b0; enter = 1'b1;
    tick(8);
    chk("t6_armed_a", 32'(state), 32'(ARMED));
    enter = 1'b0; candidate3 = 1'b1;
    tick(8);
    chk("t6_pending_a", 32'({state, vote_valid}), 32'({PENDING, 1'b1}));
    candidate3 = 1'b0; reset = 1'b1;
    tick(1);
    chk("t6_reset_pending", 32'(outs), 32'd0);
    reset = 1'b0;

    // Reset in HOLD.
    vote_ready = 1'b1; enter = 1'b1;
    tick(8);
    chk("t6_armed_b", 32'(state), 32'(ARMED));
    enter = 1'b0; candidate4 = 1'b1;
    tick(8);
    chk("t6_pending_b", 32'({state, vote_sel}), 32'({PENDING, 4'b1000}));
    candidate4 = 1'b0;
    tick(1);
    chk("t6_hold_b", 32'(state), 32'(HOLD));
    tick(2);
    reset = 1'b1;
    tick(1);
    chk("t6_reset_hold", 32'(outs), 32'd0);
    reset = 1'b0;

    // Fresh session after reset.
    UID = 6'd33; enter = 1'b1;
    tick(8);
    chk("t6_fresh_armed", 32'({state, uid_out}), 32'({ARMED, 6'd33}));
    enter = 1'b0; candidate1 = 1'b1;
    tick(8);
    chk("t6_fresh_pending", 32'({state, vote_valid, vote_sel, uid_out}),
        32'({PENDING, 1'b1, 4'b0001, 6'd33}));
    candidate1 = 1'b0;
    tick(1);
    chk("t6_fresh_hold", 32'({state, vote_done_led}), 32'({HOLD, 1'b1}));
    tick(8);
    chk("t6_fresh_idle", 32'(state), 32'(IDLE));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
